// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: run/halt/step/breakpoint controller for a single-cycle core
module proc_run_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            soft_rst,
  input  logic            run_req,
  input  logic            halt_req,
  input  logic            step_req,
  input  logic            bp_en,
  input  logic [XLEN-1:0] bp_addr,
  input  logic [XLEN-1:0] pc,
  output logic            core_en,
  output logic            core_rst,
  output logic [1:0]      state,
  output logic            halted,
  output logic            bp_hit,
  output logic            step_done,
  output logic [XLEN-1:0] cycle_cnt
);
  typedef enum logic [1:0] {S_RESET = 2'b00, S_HALT = 2'b01, S_RUN = 2'b10, S_STEP = 2'b11} state_t;
  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);
  state_t          state_q, state_d;
  logic [7:0]      rst_cnt_q, rst_cnt_d;
  logic            bp_mask_q, bp_mask_d;
  logic            bp_hit_q, bp_hit_d;
  logic            step_done_q, step_done_d;
  logic [XLEN-1:0] cycle_cnt_q, cycle_cnt_d;
  logic            bp_match;
  assign bp_match  = bp_en && (pc == bp_addr) && !bp_mask_q;
  assign core_en   = (state_q == S_RUN && !bp_match) || state_q == S_STEP;
  assign core_rst  = state_q == S_RESET;
  assign halted    = state_q == S_HALT;
  assign state     = state_q;
  assign bp_hit    = bp_hit_q;
  assign step_done = step_done_q;
  assign cycle_cnt = cycle_cnt_q;
  // Next-state logic; soft_rst overrides every state transition
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    bp_mask_d = bp_mask_q;
    bp_hit_d  = bp_hit_q;
    case (state_q)
      S_RESET: begin
        if (rst_cnt_q == 8'd0) state_d = S_HALT;
        else rst_cnt_d = rst_cnt_q - 8'd1;
      end
      S_HALT: begin
        if (step_req) state_d = S_STEP;
        else if (run_req) begin
          state_d   = S_RUN;
          bp_mask_d = 1'b1;
        end
        if (step_req || run_req) bp_hit_d = 1'b0;
      end
      S_RUN: begin
        bp_mask_d = 1'b0;
        if (bp_match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else if (halt_req) state_d = S_HALT;
      end
      S_STEP: state_d = S_HALT;
    endcase
    if (soft_rst) begin
      state_d   = S_RESET;
      rst_cnt_d = RST_LOAD;
      bp_mask_d = 1'b0;
      bp_hit_d  = 1'b0;
    end
  end
  // Step pulse and saturating committed-cycle counter
  always_comb begin
    step_done_d = state_q == S_STEP && !soft_rst;
    cycle_cnt_d = (soft_rst || state_q == S_RESET) ? '0 :
                  (core_en && cycle_cnt_q != '1) ? cycle_cnt_q + XLEN'(1) : cycle_cnt_q;
  end
  // State registers, forced to the reset sequence start by the async reset
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RESET;
      rst_cnt_q   <= RST_LOAD;
      bp_mask_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
      step_done_q <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      bp_mask_q   <= bp_mask_d;
      bp_hit_q    <= bp_hit_d;
      step_done_q <= step_done_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end
endmodule
